// File: rtl/irq_ctrl_if.sv
// Data-bus interface for the core-local interrupt controller register block.
//   i_bus_wen / i_bus_ren : write / read strobes (never both high)
//   i_bus_addr            : byte address, only exact 8-byte-aligned matches decode
//   i_bus_wdata           : 64-bit write data
//   o_bus_hit             : address is one of the mapped registers (strobe cycle)
//   o_bus_rdata           : read data, valid the cycle after i_bus_ren
interface irq_ctrl_if #(
  parameter int unsigned BUS_ADDR_MEM = 32,
  parameter int unsigned BUS_DATA_REG = 64
);
  logic                    i_bus_wen;
  logic                    i_bus_ren;
  logic [BUS_ADDR_MEM-1:0] i_bus_addr;
  logic [BUS_DATA_REG-1:0] i_bus_wdata;
  logic                    o_bus_hit;
  logic [BUS_DATA_REG-1:0] o_bus_rdata;

  modport master (
    output i_bus_wen, i_bus_ren, i_bus_addr, i_bus_wdata,
    input  o_bus_hit, o_bus_rdata
  );

  modport slave (
    input  i_bus_wen, i_bus_ren, i_bus_addr, i_bus_wdata,
    output o_bus_hit, o_bus_rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Core-local interrupt / trap-request controller.
// Holds msip, mtimecmp and mtime on the data bus, synchronises the external
// interrupt pin, and raises a held one-hot trap request towards the pipeline
// until it is acknowledged, then tracks the handler until mret retires.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   bus (slave)         : register access (see irq_ctrl_if)
//   i_ext_irq_raw       : asynchronous external interrupt level
//   i_meie/i_msie/i_mtie/i_glb_irq : enables from the CSR unit
//   i_exp_req           : synchronous exception from EX
//   i_irq_ack           : pipeline redirected to the trap vector
//   i_mret_ena          : mret retired
//   o_ext_irq/o_sft_irq/o_tmr_irq : one-hot interrupt cause
//   o_irq_src/o_exp_src : trap is interrupt / exception
//   o_trap_req          : trap request, held until acknowledged
//   o_in_trap           : handler active
//
// Build option: define IRQ_CTRL_PRESCALE_EN to advance mtime once every
// PRESCALE cycles instead of every cycle.
module irq_ctrl #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int unsigned PRESCALE   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_ctrl_if.slave        bus,
  input  logic             i_ext_irq_raw,
  input  logic             i_meie,
  input  logic             i_msie,
  input  logic             i_mtie,
  input  logic             i_glb_irq,
  input  logic             i_exp_req,
  input  logic             i_irq_ack,
  input  logic             i_mret_ena,
  output logic             o_ext_irq,
  output logic             o_sft_irq,
  output logic             o_tmr_irq,
  output logic             o_irq_src,
  output logic             o_exp_src,
  output logic             o_trap_req,
  output logic             o_in_trap
);

  localparam int unsigned DATA_W       = 64;
  localparam logic [31:0] ADDR_MSIP     = CLINT_BASE + 32'h0000_0000;
  localparam logic [31:0] ADDR_MTIMECMP = CLINT_BASE + 32'h0000_4000;
  localparam logic [31:0] ADDR_MTIME    = CLINT_BASE + 32'h0000_BFF8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  // A zero divisor would never advance mtime.
  if (PRESCALE == 0) begin : g_prescale_chk
    $error("irq_ctrl: PRESCALE must be nonzero");
  end

  state_e              state_q, state_d;
  logic                msip_q, msip_d;
  logic [DATA_W-1:0]   mtimecmp_q, mtimecmp_d;
  logic [DATA_W-1:0]   mtime_q, mtime_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sync1_q, sync2_q;
  logic                ext_q, ext_d;
  logic                sft_q, sft_d;
  logic                tmr_q, tmr_d;
  logic                irq_src_q, irq_src_d;
  logic                exp_src_q, exp_src_d;
  logic                trap_req_q, trap_req_d;
  logic                in_trap_q, in_trap_d;

  logic sel_msip, sel_mtimecmp, sel_mtime, sel_any;
  logic mtime_wr;
  logic tick;
  logic mei_p, msi_p, mti_p;
  logic mei_en, msi_en, mti_en, take;

  // Address decode; hit is only reported while a strobe is active.
  always_comb begin
    sel_msip      = (bus.i_bus_addr == ADDR_MSIP);
    sel_mtimecmp  = (bus.i_bus_addr == ADDR_MTIMECMP);
    sel_mtime     = (bus.i_bus_addr == ADDR_MTIME);
    sel_any       = sel_msip | sel_mtimecmp | sel_mtime;
    mtime_wr      = bus.i_bus_wen & sel_mtime;
  end

  assign bus.o_bus_hit   = (bus.i_bus_wen | bus.i_bus_ren) & sel_any;
  assign bus.o_bus_rdata = rdata_q;

`ifdef IRQ_CTRL_PRESCALE_EN
  localparam int unsigned     DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div_q, div_d;

  // mtime divider; a software write to mtime restarts the period.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    if (mtime_wr) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Register file next-state and registered read data.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    rdata_d    = rdata_q;

    if (bus.i_bus_wen) begin
      if (sel_msip)     msip_d     = bus.i_bus_wdata[0];
      if (sel_mtimecmp) mtimecmp_d = bus.i_bus_wdata;
      if (sel_mtime)    mtime_d    = bus.i_bus_wdata;
    end

    if (bus.i_bus_ren) begin
      rdata_d = '0;
      if (sel_msip)     rdata_d = {63'd0, msip_q};
      if (sel_mtimecmp) rdata_d = mtimecmp_q;
      if (sel_mtime)    rdata_d = mtime_q;
    end
  end

  // Pending sources, enable gating and fixed priority MEI > MSI > MTI.
  always_comb begin
    mei_p  = sync2_q;
    msi_p  = msip_q;
    mti_p  = (mtime_q >= mtimecmp_q);
    mei_en = i_meie & mei_p;
    msi_en = i_msie & msi_p;
    mti_en = i_mtie & mti_p;
    take   = i_glb_irq & (mei_en | msi_en | mti_en);
  end

  // Trap FSM next state and output values.
  always_comb begin
    state_d   = state_q;
    ext_d     = ext_q;
    sft_d     = sft_q;
    tmr_d     = tmr_q;
    irq_src_d = irq_src_q;
    exp_src_d = exp_src_q;

    case (state_q)
      ST_IDLE: begin
        if (i_exp_req) begin
          state_d   = ST_PEND;
          ext_d     = 1'b0;
          sft_d     = 1'b0;
          tmr_d     = 1'b0;
          irq_src_d = 1'b0;
          exp_src_d = 1'b1;
        end else if (take) begin
          state_d   = ST_PEND;
          ext_d     = mei_en;
          sft_d     = ~mei_en & msi_en;
          tmr_d     = ~mei_en & ~msi_en & mti_en;
          irq_src_d = 1'b1;
          exp_src_d = 1'b0;
        end
      end
      ST_PEND: begin
        if (i_irq_ack) begin
          state_d = ST_TRAP;
        end
      end
      ST_TRAP: begin
        // A fault inside the handler outranks a same-cycle mret.
        if (i_exp_req) begin
          state_d   = ST_PEND;
          ext_d     = 1'b0;
          sft_d     = 1'b0;
          tmr_d     = 1'b0;
          irq_src_d = 1'b0;
          exp_src_d = 1'b1;
        end else if (i_mret_ena) begin
          state_d   = ST_IDLE;
          ext_d     = 1'b0;
          sft_d     = 1'b0;
          tmr_d     = 1'b0;
          irq_src_d = 1'b0;
          exp_src_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ext_d     = 1'b0;
        sft_d     = 1'b0;
        tmr_d     = 1'b0;
        irq_src_d = 1'b0;
        exp_src_d = 1'b0;
      end
    endcase

    trap_req_d = (state_d == ST_PEND);
    in_trap_d  = (state_d == ST_TRAP);
  end

  // State, registers, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      rdata_q    <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      ext_q      <= 1'b0;
      sft_q      <= 1'b0;
      tmr_q      <= 1'b0;
      irq_src_q  <= 1'b0;
      exp_src_q  <= 1'b0;
      trap_req_q <= 1'b0;
      in_trap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      rdata_q    <= rdata_d;
      sync1_q    <= i_ext_irq_raw;
      sync2_q    <= sync1_q;
      ext_q      <= ext_d;
      sft_q      <= sft_d;
      tmr_q      <= tmr_d;
      irq_src_q  <= irq_src_d;
      exp_src_q  <= exp_src_d;
      trap_req_q <= trap_req_d;
      in_trap_q  <= in_trap_d;
    end
  end

  assign o_ext_irq  = ext_q;
  assign o_sft_irq  = sft_q;
  assign o_tmr_irq  = tmr_q;
  assign o_irq_src  = irq_src_q;
  assign o_exp_src  = exp_src_q;
  assign o_trap_req = trap_req_q;
  assign o_in_trap  = in_trap_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Core-local interrupt and trap-request controller: the originating end of the interrupt interface consumed by the CSR execution unit. It holds the machine timer (mtime/mtimecmp) and software-interrupt (msip) registers on the data bus and synchronises the external interrupt pin. It arbitrates against the CSR unit's enable outputs and drives one-hot interrupt/exception source signals with a held trap request until the pipeline acknowledges and `mret` retires.

## Interface
- `CLINT_BASE`, 32'h0200_0000, bus base address; msip at +0x0000, mtimecmp at +0x4000, mtime at +0xBFF8
- `PRESCALE`, 100, mtime tick divisor (used only with `IRQ_CTRL_PRESCALE_EN`)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, synchronous, active-low
- `i_bus_wen` / `i_bus_ren` in 1: bus write / read strobe
- `i_bus_addr` in `BUS_ADDR_MEM`: byte address; only 8-byte-aligned full-word accesses decoded
- `i_bus_wdata` in `BUS_DATA_REG`: write data (64 bit)
- `o_bus_hit` out 1: address falls in one of the three registers
- `o_bus_rdata` out `BUS_DATA_REG`: registered read data
- `i_ext_irq_raw` in 1: asynchronous external interrupt level
- `i_meie`, `i_msie`, `i_mtie`, `i_glb_irq` in 1 each: enables from the CSR unit
- `i_exp_req` in 1: synchronous exception raised by the instruction in EX
- `i_irq_ack` in 1: pipeline has flushed and redirected to the trap vector
- `i_mret_ena` in 1: `mret` retired
- `o_ext_irq`, `o_sft_irq`, `o_tmr_irq` out 1 each: one-hot interrupt cause
- `o_irq_src` / `o_exp_src` out 1: trap is interrupt / exception
- `o_trap_req` out 1: trap request to the pipeline
- `o_in_trap` out 1: handler active

## Operation
- External pin passes a 2-flop synchroniser: `mei_p`. `msi_p` = msip[0]. `mti_p` = (mtime >= mtimecmp), unsigned 64-bit.
- Take interrupt: `i_glb_irq & ((i_meie&mei_p)|(i_msie&msi_p)|(i_mtie&mti_p))`. Priority is MEI > MSI > MTI.
- FSM states:
  - IDLE:
    - `i_exp_req` -> PEND with `exp_src`; exception beats a same-cycle interrupt.
    - Else take -> PEND with `irq_src` and the winning one-hot cause latched.
  - PEND: `o_trap_req`=1; cause/source outputs stable. `i_irq_ack` -> TRAP. `i_exp_req` and new interrupts are ignored.
  - TRAP: `o_in_trap`=1; cause outputs held; interrupts masked.
    - `i_mret_ena` -> IDLE with all cause outputs cleared.
    - `i_exp_req` (exception inside the handler) -> PEND with source replaced by `exp_src`.
    - Exception beats mret in the same cycle.
- `i_mret_ena` in IDLE/PEND is ignored. `i_irq_ack` outside PEND is ignored.
- Registers:
  - msip: bit 0 writable, other bits read 0.
  - mtimecmp: 64-bit read/write.
  - mtime: 64-bit read/write.
  - mtime wraps 2^64-1 -> 0.
  - A bus write to mtime beats the same-cycle increment: written value loaded, no increment.
- Read of an unmapped address: `o_bus_hit`=0, `o_bus_rdata`=0. `i_bus_wen` and `i_bus_ren` are never both high.

## Timing
- Reset values: state IDLE; msip 0; mtime 0; mtimecmp all-ones (no timer interrupt out of reset); synchroniser 0; `o_bus_rdata` 0. All outputs 0.
- External pin to `mei_p`: 2 cycles. Pending to `o_trap_req`: 1 further cycle (registered FSM).
- `o_trap_req` stays high until the cycle `i_irq_ack` is sampled. It is low the next cycle.
- Bus read data is valid the cycle after `i_bus_ren`. `o_bus_hit` is combinational in the strobe cycle.
- A write to mtimecmp/msip affects `mti_p`/`msi_p` the next cycle.
- Reset mid-trap returns to IDLE in one cycle with every output 0.

## Configuration
- `IRQ_CTRL_PRESCALE_EN` defined:
  - mtime increments once every `PRESCALE` cycles via an internal divider counter reset to 0.
  - The counter also clears on an mtime write.
- Undefined: mtime increments every cycle; `PRESCALE` unused; no divider logic.

## Test plan
- Reset, prescale off: mtimecmp=10, `i_mtie`=`i_glb_irq`=1, wait -> `o_trap_req`=1 with `o_tmr_irq`=1, `o_irq_src`=1 one cycle after mtime reaches 10. Ack -> TRAP; mret -> IDLE, outputs 0.
- msip=1 and `i_ext_irq_raw`=1 together, all enables 1 -> `o_ext_irq` wins; after mret with ext still high, a new request re-asserts `o_ext_irq`.
- `i_exp_req` and pending MSI in the same IDLE cycle -> `o_exp_src`=1, `o_irq_src`=0, cause bits 0.
- In TRAP, pending timer plus `i_glb_irq`=1 -> no new request. `i_exp_req` in TRAP -> back to PEND with `o_exp_src`=1.
- mtime write 64'hFFFF_FFFF_FFFF_FFFF, then 1 cycle -> reads 0. A write coincident with a tick loads the written value exactly.
- `IRQ_CTRL_PRESCALE_EN`, `PRESCALE`=4: 40 cycles after reset -> mtime=10. Reset asserted mid-PEND -> all outputs 0 next cycle.
